// File: rtl/ysyx_22040750_ex_mem_buf.sv
// EX/MEM pipeline buffer: a two-entry in-order queue made of a head register
// and a skid register. Ready is registered, so EX never sees a combinational
// path from I_MEM_ready. A forwarding tap exposes the newest held entry that
// writes a non-zero register.
//
// Handshake: an EX transfer happens on a rising edge when
// I_result_valid && O_EX_MEM_ready. A MEM transfer happens when
// O_valid && I_MEM_ready. The head fields stay stable while O_valid is high
// and I_MEM_ready is low.
module ysyx_22040750_ex_mem_buf #(
   parameter int W_DATA = 64
) (
   input  logic              I_sys_clk,
   input  logic              I_rst,
   input  logic [W_DATA-1:0] I_result,
   input  logic [W_DATA-1:0] I_csr_data,
   input  logic [4:0]        I_rd,
   input  logic [7:0]        I_ctrl,
   input  logic              I_result_valid,
   output logic              O_EX_MEM_ready,
   input  logic              I_flush,
   input  logic              I_MEM_ready,
   output logic [W_DATA-1:0] O_result,
   output logic [W_DATA-1:0] O_csr_data,
   output logic [4:0]        O_rd,
   output logic [7:0]        O_ctrl,
   output logic              O_valid,
   output logic              O_fwd_valid,
   output logic [4:0]        O_fwd_rd,
   output logic [W_DATA-1:0] O_fwd_data,
   output logic [1:0]        O_dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } state_t;

   // One queued entry; ctrl = {wen, csr_wen, mem_ren, mem_wen, size[2:0], sext}
   typedef struct packed {
      logic [W_DATA-1:0] result;
      logic [W_DATA-1:0] csr;
      logic [4:0]        rd;
      logic [7:0]        ctrl;
   } ent_t;

   state_t r_state;
   state_t w_next;
   logic   r_valid;
   logic   r_ready;
   ent_t   r_head;
   ent_t   r_skid;
   ent_t   w_in;
   logic   w_ex_xfer;
   logic   w_mem_xfer;
   logic   w_load_head;
   logic   w_load_skid;
   logic   w_skid_to_head;
   logic   w_head_hit;
   logic   w_skid_hit;

   assign w_in       = '{result: I_result, csr: I_csr_data, rd: I_rd, ctrl: I_ctrl};
   assign w_ex_xfer  = I_result_valid & r_ready;
   assign w_mem_xfer = r_valid & I_MEM_ready;

   // Next-state and register-load decode; flush drops everything, including
   // an EX entry offered in the same cycle.
   always_comb begin
      w_next         = r_state;
      w_load_head    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_head = 1'b0;
      if (I_flush) begin
         w_next = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_ex_xfer) begin
                  w_load_head = 1'b1;
                  w_next      = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_ex_xfer && w_mem_xfer) begin
                  w_load_head = 1'b1;
                  w_next      = ST_ONE;
               end else if (w_ex_xfer) begin
                  w_load_skid = 1'b1;
                  w_next      = ST_TWO;
               end else if (w_mem_xfer) begin
                  w_next = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_mem_xfer) begin
                  w_skid_to_head = 1'b1;
                  w_next         = ST_ONE;
               end
            end
            default: w_next = ST_EMPTY;
         endcase
      end
   end

   // State register with the registered valid/ready flags derived from it
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         r_state <= ST_EMPTY;
         r_valid <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_next;
         r_valid <= (w_next != ST_EMPTY);
         r_ready <= (w_next != ST_TWO);
      end
   end

   // Data registers carry no reset; outputs are masked while nothing is held
   always_ff @(posedge I_sys_clk) begin
      if (w_load_head) begin
         r_head <= w_in;
      end else if (w_skid_to_head) begin
         r_head <= r_skid;
      end
      if (w_load_skid) begin
         r_skid <= w_in;
      end
   end

   assign O_valid        = r_valid;
   assign O_EX_MEM_ready = r_ready;
   assign O_dbg_state    = r_state;
   assign O_result       = r_valid ? r_head.result : '0;
   assign O_csr_data     = r_valid ? r_head.csr    : '0;
   assign O_rd           = r_valid ? r_head.rd     : 5'd0;
   assign O_ctrl         = r_valid ? r_head.ctrl   : 8'd0;

   assign w_skid_hit = (r_state == ST_TWO) & r_skid.ctrl[7] & (r_skid.rd != 5'd0);
   assign w_head_hit = r_valid & r_head.ctrl[7] & (r_head.rd != 5'd0);

   // Forwarding tap: the skid entry is younger, so it wins over the head
   always_comb begin
      O_fwd_valid = 1'b0;
      O_fwd_rd    = 5'd0;
      O_fwd_data  = '0;
      if (w_skid_hit) begin
         O_fwd_valid = 1'b1;
         O_fwd_rd    = r_skid.rd;
         O_fwd_data  = r_skid.result;
      end else if (w_head_hit) begin
         O_fwd_valid = 1'b1;
         O_fwd_rd    = r_head.rd;
         O_fwd_data  = r_head.result;
      end
   end

endmodule

// File: tb/tb_ysyx_22040750_ex_mem_buf.sv
// Bench for the EX/MEM buffer: directed vector table, an in-order stream
// check, then random traffic against a queue-based reference model.
module tb_ysyx_22040750_ex_mem_buf;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [W-1:0] result;
  logic [W-1:0] csr_data;
  logic [4:0]   rd;
  logic [7:0]   ctrl;
  logic         result_valid;
  logic         ex_mem_ready;
  logic         flush;
  logic         mem_ready;
  logic [W-1:0] o_result;
  logic [W-1:0] o_csr_data;
  logic [4:0]   o_rd;
  logic [7:0]   o_ctrl;
  logic         o_valid;
  logic         fwd_valid;
  logic [4:0]   fwd_rd;
  logic [W-1:0] fwd_data;
  logic [1:0]   dbg_state;

  ysyx_22040750_ex_mem_buf #(.W_DATA(W)) dut (
    .I_sys_clk      (clk),
    .I_rst          (rst),
    .I_result       (result),
    .I_csr_data     (csr_data),
    .I_rd           (rd),
    .I_ctrl         (ctrl),
    .I_result_valid (result_valid),
    .O_EX_MEM_ready (ex_mem_ready),
    .I_flush        (flush),
    .I_MEM_ready    (mem_ready),
    .O_result       (o_result),
    .O_csr_data     (o_csr_data),
    .O_rd           (o_rd),
    .O_ctrl         (o_ctrl),
    .O_valid        (o_valid),
    .O_fwd_valid    (fwd_valid),
    .O_fwd_rd       (fwd_rd),
    .O_fwd_data     (fwd_data),
    .O_dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [W-1:0] result;
    logic [W-1:0] csr;
    logic [4:0]   rd;
    logic [7:0]   ctrl;
  } ent_t;

  ent_t         m_q[$];       // reference model: entries held, oldest first
  logic [W-1:0] exp_q[$];     // expected MEM output order for the stream test

  typedef struct {
    logic         rst, flush, valid, mr;
    logic [W-1:0] result;
    logic [4:0]   rd;
    logic [7:0]   ctrl;
    logic         e_valid, e_ready;
    logic [W-1:0] e_result;
    logic         e_fv;
    logic [4:0]   e_frd;
    logic [W-1:0] e_fdata;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: one clock edge of a 2-deep FIFO with flush and reset
  task automatic model_edge();
    bit ex_x, mem_x;
    ex_x  = result_valid && (m_q.size() < 2);
    mem_x = (m_q.size() > 0) && mem_ready;
    if (rst || flush) begin
      m_q.delete();
    end else begin
      if (mem_x) void'(m_q.pop_front());
      if (ex_x) m_q.push_back('{result: result, csr: csr_data, rd: rd, ctrl: ctrl});
    end
  endtask

  task automatic check_model(input string tag);
    ent_t         h;
    logic         fv;
    logic [4:0]   frd;
    logic [W-1:0] fd;
    h   = '0;
    fv  = 1'b0;
    frd = 5'd0;
    fd  = '0;
    if (m_q.size() > 0) h = m_q[0];
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (!fv && m_q[i].ctrl[7] && m_q[i].rd != 5'd0) begin
        fv  = 1'b1;
        frd = m_q[i].rd;
        fd  = m_q[i].result;
      end
    end
    check({tag, ".valid"},    W'(o_valid),      W'(m_q.size() > 0));
    check({tag, ".ready"},    W'(ex_mem_ready), W'(m_q.size() < 2));
    check({tag, ".result"},   o_result,         h.result);
    check({tag, ".csr"},      o_csr_data,       h.csr);
    check({tag, ".rd"},       W'(o_rd),         W'(h.rd));
    check({tag, ".ctrl"},     W'(o_ctrl),       W'(h.ctrl));
    check({tag, ".fwd_v"},    W'(fwd_valid),    W'(fv));
    check({tag, ".fwd_rd"},   W'(fwd_rd),       W'(frd));
    check({tag, ".fwd_data"}, fwd_data,         fd);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic i_rst, input logic i_flush, input logic i_valid,
                      input logic i_mr, input logic [W-1:0] i_res, input logic [W-1:0] i_csr,
                      input logic [4:0] i_rd, input logic [7:0] i_ctrl);
    rst          = i_rst;
    flush        = i_flush;
    result_valid = i_valid;
    mem_ready    = i_mr;
    result       = i_res;
    csr_data     = i_csr;
    rd           = i_rd;
    ctrl         = i_ctrl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic v, input logic m,
                              input logic [W-1:0] res, input logic [4:0] d, input logic [7:0] c,
                              input logic ev, input logic er, input logic [W-1:0] eres,
                              input logic efv, input logic [4:0] efrd, input logic [W-1:0] efd);
    vec_t x;
    x.rst = r; x.flush = f; x.valid = v; x.mr = m;
    x.result = res; x.rd = d; x.ctrl = c;
    x.e_valid = ev; x.e_ready = er; x.e_result = eres;
    x.e_fv = efv; x.e_frd = efrd; x.e_fdata = efd;
    return x;
  endfunction

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; result_valid = 1'b0; mem_ready = 1'b0;
    result = '0; csr_data = '0; rd = '0; ctrl = '0;

    // Directed vectors: {rst,flush,valid,mr,result,rd,ctrl} -> post-edge outputs
    // empty load, then drain
    tbl.push_back(mk(1,0,0,0, 64'h0,    0, 8'h00,  0,1, 64'h0,    0,0, 64'h0));
    tbl.push_back(mk(0,0,1,1, 64'h1234, 5, 8'h80,  1,1, 64'h1234, 1,5, 64'h1234));
    tbl.push_back(mk(0,0,0,1, 64'h0,    0, 8'h00,  0,1, 64'h0,    0,0, 64'h0));
    // backpressure: A then B held, extra offer refused, drain in order
    tbl.push_back(mk(0,0,1,0, 64'hA,    1, 8'h80,  1,1, 64'hA,    1,1, 64'hA));
    tbl.push_back(mk(0,0,1,0, 64'hB,    2, 8'h80,  1,0, 64'hA,    1,2, 64'hB));
    tbl.push_back(mk(0,0,1,0, 64'hD,    7, 8'h80,  1,0, 64'hA,    1,2, 64'hB));
    tbl.push_back(mk(0,0,0,1, 64'h0,    0, 8'h00,  1,1, 64'hB,    1,2, 64'hB));
    tbl.push_back(mk(0,0,0,1, 64'h0,    0, 8'h00,  0,1, 64'h0,    0,0, 64'h0));
    // flush from TWO with a concurrent offer of C
    tbl.push_back(mk(0,0,1,0, 64'hA,    1, 8'h80,  1,1, 64'hA,    1,1, 64'hA));
    tbl.push_back(mk(0,0,1,0, 64'hB,    2, 8'h80,  1,0, 64'hA,    1,2, 64'hB));
    tbl.push_back(mk(0,1,1,0, 64'hC,    3, 8'h80,  0,1, 64'h0,    0,0, 64'h0));
    tbl.push_back(mk(0,0,0,1, 64'h0,    0, 8'h00,  0,1, 64'h0,    0,0, 64'h0));
    // forwarding priority: skid beats head for the same rd
    tbl.push_back(mk(0,0,1,0, 64'h1,    3, 8'h80,  1,1, 64'h1,    1,3, 64'h1));
    tbl.push_back(mk(0,0,1,0, 64'h2,    3, 8'h80,  1,0, 64'h1,    1,3, 64'h2));
    tbl.push_back(mk(0,0,0,1, 64'h0,    0, 8'h00,  1,1, 64'h2,    1,3, 64'h2));
    // rd=0 entries never forward (simultaneous push/pop in ONE, then fill)
    tbl.push_back(mk(0,0,1,1, 64'h5,    0, 8'h80,  1,1, 64'h5,    0,0, 64'h0));
    tbl.push_back(mk(0,0,1,0, 64'h6,    0, 8'h80,  1,0, 64'h5,    0,0, 64'h0));
    // reset in TWO drops both entries
    tbl.push_back(mk(1,0,1,1, 64'h9,    4, 8'h80,  0,1, 64'h0,    0,0, 64'h0));
    // wen=0 does not forward; wen=1 in skid does
    tbl.push_back(mk(0,0,1,0, 64'h7,    4, 8'h40,  1,1, 64'h7,    0,0, 64'h0));
    tbl.push_back(mk(0,0,1,0, 64'h8,    4, 8'h80,  1,0, 64'h7,    1,4, 64'h8));
    // flush with a concurrent MEM transfer, then recover
    tbl.push_back(mk(0,1,0,1, 64'h0,    0, 8'h00,  0,1, 64'h0,    0,0, 64'h0));
    tbl.push_back(mk(0,0,1,0, 64'h9,    6, 8'h80,  1,1, 64'h9,    1,6, 64'h9));
    // reset priority over flush and transfers
    tbl.push_back(mk(1,1,1,1, 64'hE,    6, 8'h80,  0,1, 64'h0,    0,0, 64'h0));

    // Reset state: all head and forwarding fields read zero
    repeat (2) step(1, 0, 0, 0, '0, '0, '0, '0);
    check("rst.valid",    W'(o_valid),      W'(0));
    check("rst.ready",    W'(ex_mem_ready), W'(1));
    check("rst.result",   o_result,         W'(0));
    check("rst.csr",      o_csr_data,       W'(0));
    check("rst.rd",       W'(o_rd),         W'(0));
    check("rst.ctrl",     W'(o_ctrl),       W'(0));
    check("rst.fwd_v",    W'(fwd_valid),    W'(0));
    check("rst.fwd_rd",   W'(fwd_rd),       W'(0));
    check("rst.fwd_data", fwd_data,         W'(0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].mr,
           tbl[i].result, '0, tbl[i].rd, tbl[i].ctrl);
      check($sformatf("vec%0d.valid", i),  W'(o_valid),      W'(tbl[i].e_valid));
      check($sformatf("vec%0d.ready", i),  W'(ex_mem_ready), W'(tbl[i].e_ready));
      check($sformatf("vec%0d.result", i), o_result,         tbl[i].e_result);
      check($sformatf("vec%0d.fwd_v", i),  W'(fwd_valid),    W'(tbl[i].e_fv));
      check($sformatf("vec%0d.fwd_rd", i), W'(fwd_rd),       W'(tbl[i].e_frd));
      check($sformatf("vec%0d.fwd_d", i),  fwd_data,         tbl[i].e_fdata);
    end

    // Streaming: 16 back-to-back values with MEM always ready
    step(1, 0, 0, 0, '0, '0, '0, '0);
    exp_q.delete();
    seen = 0;
    for (int k = 0; k < 17; k++) begin
      if (k < 16) exp_q.push_back(W'(64'h100 + k));
      step(0, 0, k < 16, 1, W'(64'h100 + k), '0, 5'd1, 8'h80);
      check($sformatf("stream%0d.ready", k), W'(ex_mem_ready), W'(1));
      if (o_valid) begin
        seen++;
        if (exp_q.size() > 0) check($sformatf("stream%0d.data", k), o_result, exp_q.pop_front());
        else check($sformatf("stream%0d.extra", k), W'(1), W'(0));
      end
    end
    check("stream.count", W'(seen), W'(16));

    // Random traffic against the queue model
    step(1, 0, 0, 0, '0, '0, '0, '0);
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(63, 0) == 0, $urandom_range(15, 0) == 0,
           $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
           {$urandom, $urandom}, {$urandom, $urandom},
           5'($urandom_range(3, 0)), 8'($urandom));
      check_model($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
